// File: rtl/ud_counter_sched_pkg.sv
// Shared state encoding and constants for the ud_counter_sched frame sequencer.
package ud_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_SETTLE,
        ST_HOLD
    } sched_state_t;

    localparam int SETTLE_CYC = 2;

    // Value the attached counter resets to: the mid-scale code for a cw-bit counter.
    function automatic logic [31:0] midscale(input int cw);
        return 32'd1 << (cw - 1);
    endfunction

endpackage

// File: rtl/ud_counter_sched_if.sv
// Requester, counter-control and result-handshake signals of ud_counter_sched.
interface ud_counter_sched_if #(
    parameter int N_REQ = 4,
    parameter int CW    = 16
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir;
    logic [N_REQ-1:0] ack;
    logic [CW-1:0]    ctr_q;
    logic             ctr_en;
    logic             ctr_u_d;
    logic             ctr_rstb;
    logic [CW-1:0]    res_data;
    logic             res_sat;
    logic             res_err;
    logic             res_valid;
    logic             res_ready;

    modport master (
        input  req, dir, ctr_q, res_ready,
        output ack, ctr_en, ctr_u_d, ctr_rstb, res_data, res_sat, res_err, res_valid
    );

    modport slave (
        output req, dir, ctr_q, res_ready,
        input  ack, ctr_en, ctr_u_d, ctr_rstb, res_data, res_sat, res_err, res_valid
    );
endinterface

// File: rtl/ud_counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             found
);
    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
endmodule

// File: rtl/ud_counter_sched.sv
// Frame sequencer and round-robin event arbiter driving one shared up/down counter,
// with a saturating shadow count that both suppresses wrap-around and cross-checks the counter.
module ud_counter_sched
    import ud_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CW      = 16,
    parameter int WINDOW  = 256,
    parameter int CLR_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic continuous,
    output logic busy,
    ud_counter_sched_if.master bus
);
    localparam int PW        = $clog2(N_REQ);
    localparam int MAX_AB    = (WINDOW > CLR_CYC) ? WINDOW : CLR_CYC;
    localparam int PHASE_MAX = (MAX_AB > SETTLE_CYC) ? MAX_AB : SETTLE_CYC;
    localparam int TW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [CW-1:0] MIDSCALE = CW'(midscale(CW));
    localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

    sched_state_t     state, next_state;
    logic [TW-1:0]    phase_cnt;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             gnt_found;
    logic             gnt_dir;
    logic             at_bound;
    logic [CW-1:0]    shadow;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    assign bus.ack  = (state == ST_COUNT) ? gnt : '0;
    assign gnt_dir  = bus.dir[gnt_idx];
    assign at_bound = gnt_dir ? (&shadow) : (shadow == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_CLEAR;
            ST_CLEAR:  if (phase_cnt == '0) next_state = ST_COUNT;
            ST_COUNT:  if (phase_cnt == '0) next_state = ST_SETTLE;
            ST_SETTLE: if (phase_cnt == '0) next_state = ST_HOLD;
            ST_HOLD:   if (bus.res_valid && bus.res_ready)
                           next_state = continuous ? ST_CLEAR : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt     <= '0;
            rr_ptr        <= '0;
            shadow        <= MIDSCALE;
            bus.ctr_en    <= 1'b0;
            bus.ctr_u_d   <= 1'b1;
            bus.ctr_rstb  <= 1'b0;
            bus.res_data  <= '0;
            bus.res_sat   <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.ctr_rstb <= (next_state != ST_CLEAR);
            busy         <= (next_state != ST_IDLE);
            bus.ctr_en   <= 1'b0;

            if (state != next_state) begin
                case (next_state)
                    ST_CLEAR:  phase_cnt <= TW'(CLR_CYC - 1);
                    ST_COUNT:  phase_cnt <= TW'(WINDOW - 1);
                    ST_SETTLE: phase_cnt <= TW'(SETTLE_CYC - 1);
                    default:   phase_cnt <= '0;
                endcase
            end else if (phase_cnt != '0) begin
                phase_cnt <= phase_cnt - 1'b1;
            end

            if (next_state == ST_CLEAR) begin
                shadow      <= MIDSCALE;
                bus.res_sat <= 1'b0;
            end

            // A grant at a bound is still consumed, but the counter is not pulsed.
            if (state == ST_COUNT && gnt_found) begin
                rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
                if (at_bound) begin
                    bus.res_sat <= 1'b1;
                end else begin
                    bus.ctr_en  <= 1'b1;
                    bus.ctr_u_d <= gnt_dir;
                    shadow      <= gnt_dir ? shadow + 1'b1 : shadow - 1'b1;
                end
            end

            if (state == ST_SETTLE && next_state == ST_HOLD) begin
                bus.res_data  <= bus.ctr_q;
                bus.res_err   <= (bus.ctr_q != shadow);
                bus.res_valid <= 1'b1;
            end else if (state == ST_HOLD && bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ud_counter_sched.sv
// Randomized self-checking bench for ud_counter_sched with attached behavioural up/down counters.
module tb_ud_counter_sched;
    localparam int N_REQ   = 4;
    localparam int CW      = 16;
    localparam int WINDOW  = 16;
    localparam int CLR_CYC = 2;
    localparam int CW4     = 4;
    localparam int WINDOW4 = 10;
    localparam int SETTLE  = 2;
    localparam int MID     = 1 << (CW - 1);
    localparam int MAXV    = (1 << CW) - 1;
    localparam int MODE_UP0  = 0;
    localparam int MODE_ALL  = 1;
    localparam int MODE_RAND = 2;

    logic clk = 1'b0;
    logic rst;
    logic start, continuous, busy;
    logic start4, continuous4, busy4;

    int n_checks = 0;
    int n_fail   = 0;
    bit pend[N_REQ];
    bit pend_dir[N_REQ];
    int wait_cnt[N_REQ];
    int m_ptr, m_shadow, max_wait, obs_acks, ack4_cnt;
    bit m_sat, exp_en, exp_ud;

    always #5 clk = ~clk;

    ud_counter_sched_if #(.N_REQ(N_REQ), .CW(CW))  bus16 ();
    ud_counter_sched_if #(.N_REQ(N_REQ), .CW(CW4)) bus4 ();

    ud_counter_sched #(.N_REQ(N_REQ), .CW(CW), .WINDOW(WINDOW), .CLR_CYC(CLR_CYC)) dut16 (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .busy(busy), .bus(bus16)
    );

    ud_counter_sched #(.N_REQ(N_REQ), .CW(CW4), .WINDOW(WINDOW4), .CLR_CYC(CLR_CYC)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .continuous(continuous4), .busy(busy4), .bus(bus4)
    );

    // Attached counters: mid-scale async active-low clear, count on enable.
    always @(posedge clk or negedge bus16.ctr_rstb)
        if (!bus16.ctr_rstb)    bus16.ctr_q <= 16'h8000;
        else if (bus16.ctr_en)  bus16.ctr_q <= bus16.ctr_u_d ? bus16.ctr_q + 16'd1 : bus16.ctr_q - 16'd1;

    always @(posedge clk or negedge bus4.ctr_rstb)
        if (!bus4.ctr_rstb)     bus4.ctr_q <= 4'h8;
        else if (bus4.ctr_en)   bus4.ctr_q <= bus4.ctr_u_d ? bus4.ctr_q + 4'd1 : bus4.ctr_q - 4'd1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time %0t reached limit 200000 before end of test", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requesters hold an event until it is acknowledged, then may post a new one.
    task automatic applyStimulus(input int mode);
        for (int i = 0; i < N_REQ; i++) begin
            case (mode)
                MODE_UP0: begin pend[i] = (i == 0); pend_dir[i] = (i == 0); end
                MODE_ALL: begin pend[i] = 1'b1;     pend_dir[i] = (i % 2 == 0); end
                default: if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]     = 1'b1;
                    pend_dir[i] = ($urandom_range(0, 1) == 1);
                end
            endcase
            bus16.req[i] = pend[i];
            bus16.dir[i] = pend_dir[i];
        end
    endtask

    function automatic int modelGrant();
        for (int k = 0; k < N_REQ; k++)
            if (pend[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        return -1;
    endfunction

    task automatic runFrame(input int mode, input int hold_wait, input bit from_hold, input bit cont);
        int g;
        if (!from_hold) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        m_shadow = MID; m_sat = 1'b0; exp_en = 1'b0; max_wait = 0; obs_acks = 0;
        for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;

        for (int c = 0; c < CLR_CYC; c++) begin
            checkOutput("clear_rstb", bus16.ctr_rstb, 0);
            checkOutput("clear_busy", busy, 1);
            applyStimulus(mode);
            #1 checkOutput("clear_ack", bus16.ack, 0);
            tick();
        end
        checkOutput("count_rstb", bus16.ctr_rstb, 1);

        for (int c = 0; c < WINDOW; c++) begin
            checkOutput("count_en", bus16.ctr_en, exp_en);
            if (exp_en) checkOutput("count_ud", bus16.ctr_u_d, exp_ud);
            applyStimulus(mode);
            #1;
            g = modelGrant();
            checkOutput("count_ack", bus16.ack, (g < 0) ? 32'd0 : (32'd1 << g));
            if (bus16.ack != '0) obs_acks++;
            for (int i = 0; i < N_REQ; i++) begin
                if (pend[i] && !bus16.ack[i]) wait_cnt[i]++;
                else                          wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            exp_en = 1'b0;
            if (g >= 0) begin
                m_ptr  = (g + 1) % N_REQ;
                pend[g] = 1'b0;
                if ((pend_dir[g] && m_shadow == MAXV) || (!pend_dir[g] && m_shadow == 0)) begin
                    m_sat = 1'b1;
                end else begin
                    exp_en   = 1'b1;
                    exp_ud   = pend_dir[g];
                    m_shadow = pend_dir[g] ? m_shadow + 1 : m_shadow - 1;
                end
            end
            tick();
        end

        for (int c = 0; c < SETTLE; c++) begin
            checkOutput("settle_en", bus16.ctr_en, exp_en);
            exp_en = 1'b0;
            applyStimulus(mode);
            #1 checkOutput("settle_ack", bus16.ack, 0);
            tick();
        end

        checkOutput("hold_valid", bus16.res_valid, 1);
        checkOutput("hold_data", bus16.res_data, m_shadow);
        checkOutput("hold_sat", bus16.res_sat, m_sat);
        checkOutput("hold_err", bus16.res_err, 0);
        checkOutput("hold_en", bus16.ctr_en, 0);
        checkOutput("hold_rstb", bus16.ctr_rstb, 1);
        bus16.res_ready = 1'b0;
        for (int c = 0; c < hold_wait; c++) begin
            applyStimulus(mode);
            #1 checkOutput("stall_ack", bus16.ack, 0);
            tick();
            checkOutput("stall_valid", bus16.res_valid, 1);
            checkOutput("stall_data", bus16.res_data, m_shadow);
            checkOutput("stall_busy", busy, 1);
        end
        continuous      = cont;
        bus16.res_ready = 1'b1;
        applyStimulus(mode);
        #1 checkOutput("accept_ack", bus16.ack, 0);
        tick();
        bus16.res_ready = 1'b0;
        continuous      = 1'b0;
        checkOutput("post_valid", bus16.res_valid, 0);
        checkOutput("post_busy", busy, cont);
        if (cont) checkOutput("post_rstb", bus16.ctr_rstb, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; start4 = 1'b0; continuous4 = 1'b0;
        bus16.req = '0; bus16.dir = '0; bus16.res_ready = 1'b0;
        bus4.req  = '0; bus4.dir  = '0; bus4.res_ready  = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b0; pend_dir[i] = 1'b0; end
        repeat (3) tick();
        bus16.req = 4'b1111;
        #1;
        checkOutput("rst_ack", bus16.ack, 0);
        checkOutput("rst_en", bus16.ctr_en, 0);
        checkOutput("rst_ud", bus16.ctr_u_d, 1);
        checkOutput("rst_rstb", bus16.ctr_rstb, 0);
        checkOutput("rst_data", bus16.res_data, 0);
        checkOutput("rst_flags", {bus16.res_sat, bus16.res_err, bus16.res_valid}, 0);
        checkOutput("rst_busy", busy, 0);
        bus16.req = '0;
        rst = 1'b0;
        tick();
        checkOutput("idle_rstb", bus16.ctr_rstb, 1);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] single up requester");
        runFrame(MODE_UP0, 0, 1'b0, 1'b0);
        checkOutput("t1_data", bus16.res_data, 32'h8010);
        checkOutput("t1_acks", obs_acks, WINDOW);

        $display("[TB] all requesters, alternating directions");
        runFrame(MODE_ALL, 0, 1'b0, 1'b0);
        checkOutput("t2_data", bus16.res_data, 32'h8000);
        checkOutput("t2_starve", (max_wait <= 3), 1);

        $display("[TB] random events with a 20-cycle result stall");
        runFrame(MODE_RAND, 20, 1'b0, 1'b0);

        $display("[TB] continuous back-to-back frames");
        runFrame(MODE_RAND, 3, 1'b0, 1'b1);
        runFrame(MODE_UP0, 0, 1'b1, 1'b0);
        checkOutput("t5_data", bus16.res_data, 32'h8010);

        $display("[TB] reset in the middle of a window");
        start = 1'b1; tick(); start = 1'b0;
        bus16.req = 4'b1111; bus16.dir = 4'b1111;
        repeat (CLR_CYC + 5) tick();
        rst = 1'b1;
        tick();
        #1;
        checkOutput("mid_rst_ack", bus16.ack, 0);
        checkOutput("mid_rst_en", bus16.ctr_en, 0);
        checkOutput("mid_rst_rstb", bus16.ctr_rstb, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ctr", bus16.ctr_q, 32'h8000);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        bus16.req = '0;
        repeat (2) tick();
        runFrame(MODE_RAND, 0, 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) runFrame(MODE_RAND, int'($urandom_range(0, 4)), 1'b0, 1'b0);

        $display("[TB] 4-bit counter saturation");
        bus4.req = 4'b0010; bus4.dir = 4'b0010;
        start4 = 1'b1; tick(); start4 = 1'b0;
        ack4_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus4.res_valid) break;
            ack4_cnt += $countones(bus4.ack);
            tick();
        end
        checkOutput("t3_valid", bus4.res_valid, 1);
        checkOutput("t3_data", bus4.res_data, 32'hF);
        checkOutput("t3_sat", bus4.res_sat, 1);
        checkOutput("t3_err", bus4.res_err, 0);
        checkOutput("t3_acks", ack4_cnt, WINDOW4);
        checkOutput("t3_ctr", bus4.ctr_q, 32'hF);
        bus4.res_ready = 1'b1;
        tick();
        bus4.res_ready = 1'b0;
        checkOutput("t3_idle", busy4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
